// File: rtl/dm_run_arbiter.sv
// Run controller and single-port data-memory arbiter between the core dm port and a host port.
// Optional HOST_INTERLEAVE_EN: host accesses slip into idle core cycles during START/RUN.
module dm_run_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_clear,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  run_cycles,
    output logic                  core_start,
    input  logic                  core_stop,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_w_data,
    output logic [DATA_WIDTH-1:0] core_r_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    logic   rd_pend;
    logic   core_own;
    logic   host_grant;

    assign core_own = (state == START) || (state == RUN);

`ifdef HOST_INTERLEAVE_EN
    assign host_grant = host_req && (!core_own || (!core_rd && !core_wr));
`else
    assign host_grant = host_req && !core_own;
`endif

    // Gated by rst so every output except the read pass-through is 0 in reset.
    assign host_ack    = rst && host_grant;
    assign host_rvalid = rd_pend;
    assign host_rdata  = rd_pend ? mem_r_data : '0;
    assign core_r_data = mem_r_data;

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_w_data = '0;
        if (host_ack) begin
            mem_rd     = !host_we;
            mem_wr     = host_we;
            mem_addr   = host_addr;
            mem_w_data = host_wdata;
        end else if (rst && core_own) begin
            // A simultaneous core rd+wr performs only the write.
            mem_rd     = core_rd && !core_wr;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_w_data = core_w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_start <= 1'b0;
            run_cycles <= '0;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend <= host_ack && !host_we;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        state      <= START;
                        busy       <= 1'b1;
                        core_start <= 1'b1;
                        run_cycles <= '0;
                    end
                end
                START: begin
                    state      <= RUN;
                    core_start <= 1'b0;
                end
                RUN: begin
                    if (run_cycles != '1)
                        run_cycles <= run_cycles + CNT_ONE;
                    if (core_stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (cmd_start) begin
                        state      <= START;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        core_start <= 1'b1;
                        run_cycles <= '0;
                    end else if (cmd_clear) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    core_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_run_arbiter.sv
// Directed bench for dm_run_arbiter with a behavioural 1-cycle-read memory and a CNT_WIDTH=4 twin.
module tb_dm_run_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 0, cmd_clear = 0, core_stop = 0;
    logic        core_rd = 0, core_wr = 0;
    logic [7:0]  core_addr = 0;
    logic [15:0] core_w_data = 0;
    logic        host_req = 0, host_we = 0;
    logic [7:0]  host_addr = 0;
    logic [15:0] host_wdata = 0;
    logic        busy, done, core_start, host_ack, host_rvalid, mem_rd, mem_wr;
    logic [15:0] run_cycles, core_r_data, host_rdata, mem_w_data, mem_r_data;
    logic [7:0]  mem_addr;
    logic        s_busy, s_done, s_core_start, s_host_ack, s_host_rvalid, s_mem_rd, s_mem_wr;
    logic [3:0]  s_run_cycles;
    logic [15:0] s_core_r_data, s_host_rdata, s_mem_w_data;
    logic [7:0]  s_mem_addr;
    logic [15:0] mem [256];
    int errors = 0, checks = 0, cs_cnt = 0;
    bit il;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_w_data;
        if (mem_rd) mem_r_data <= mem[mem_addr];
    end

    always @(negedge clk) if (core_start) cs_cnt++;

    dm_run_arbiter dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
        .busy(busy), .done(done), .run_cycles(run_cycles), .core_start(core_start),
        .core_stop(core_stop), .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_w_data(core_w_data), .core_r_data(core_r_data), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data));

    dm_run_arbiter #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
        .busy(s_busy), .done(s_done), .run_cycles(s_run_cycles), .core_start(s_core_start),
        .core_stop(core_stop), .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_w_data(core_w_data), .core_r_data(s_core_r_data), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(s_host_ack),
        .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
        .mem_addr(s_mem_addr), .mem_w_data(s_mem_w_data), .mem_r_data(mem_r_data));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef HOST_INTERLEAVE_EN
        il = 1'b1;
`else
        il = 1'b0;
`endif
        // Reset: outputs quiet even with host and core active.
        host_req = 1; host_we = 1; core_wr = 1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cycles", run_cycles, 0);
        chk("rst_cstart", core_start, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_memwr", mem_wr, 0);
        chk("rst_rvalid", host_rvalid, 0);
        host_req = 0; core_wr = 0;
        tick();
        rst = 1;
        tick();

        // IDLE: core enables dropped, core_stop ignored.
        core_wr = 1; core_stop = 1; #1;
        chk("idle_corewr", mem_wr, 0);
        tick();
        chk("idle_stop_done", done, 0);
        core_wr = 0; core_stop = 0;

        // Preload then back-to-back readback.
        host_req = 1; host_we = 1; host_addr = 1; host_wdata = 16'h000A; #1;
        chk("wr1_ack", host_ack, 1);
        chk("wr1_memwr", mem_wr, 1);
        tick();
        host_addr = 2; host_wdata = 16'h0005; #1;
        chk("wr2_ack", host_ack, 1);
        tick();
        host_we = 0; host_addr = 1; #1;
        chk("rd1_ack", host_ack, 1);
        tick();
        host_addr = 2; #1;
        chk("rd2_ack", host_ack, 1);
        chk("rd1_rvalid", host_rvalid, 1);
        chk("rd1_data", host_rdata, 16'h000A);
        tick();
        host_req = 0; #1;
        chk("rd2_rvalid", host_rvalid, 1);
        chk("rd2_data", host_rdata, 16'h0005);
        tick();
        chk("rd_rvalid_off", host_rvalid, 0);
        chk("rd_rdata_zero", host_rdata, 0);

        // Run: 7 RUN cycles, core writes 10 to addr 1 in the first.
        cmd_start = 1;
        tick();
        cmd_start = 0; #1;
        chk("run_cstart", core_start, 1);
        chk("run_busy", busy, 1);
        tick();
        chk("run_cstart_off", core_start, 0);
        for (int i = 1; i <= 7; i++) begin
            core_wr = (i == 1); core_addr = 1; core_w_data = 16'd10;
            core_stop = (i == 7); #1;
            if (i == 1) chk("run_core_memwr", mem_wr, 1);
            tick();
        end
        core_wr = 0; core_stop = 0;
        chk("run_done", done, 1);
        chk("run_busy_off", busy, 0);
        chk("run_cycles7", run_cycles, 7);
        chk("run_cstart_cnt", cs_cnt, 1);
        chk("run_mem1", mem[1], 16'd10);
        cmd_clear = 1;
        tick();
        cmd_clear = 0;
        chk("clr_done", done, 0);
        chk("clr_cycles", run_cycles, 7);
        chk("clr_idle_busy", busy, 0);

        // Host contention in RUN.
        cmd_start = 1;
        tick();
        cmd_start = 0;
        tick();
        host_req = 1; host_we = 0; host_addr = 2;
        for (int i = 0; i < 3; i++) begin
            core_rd = 1; core_addr = 8'h10; #1;
            chk("cont_ack_blk", host_ack, 0);
            chk("cont_memaddr", mem_addr, 8'h10);
            tick();
        end
        core_rd = 0; #1;
        chk("cont_idle_ack", host_ack, il);
        tick();
        if (il) host_req = 0;
        core_rd = 1; core_wr = 1; core_addr = 3; core_w_data = 16'h0033; #1;
        chk("rdwr_memwr", mem_wr, 1);
        chk("rdwr_memrd", mem_rd, 0);
        chk("cont_rvalid", host_rvalid, il);
        chk("cont_rdata", host_rdata, il ? 16'h0005 : 16'h0000);
        tick();
        core_rd = 0; core_wr = 0; core_stop = 1; #1;
        chk("cont_stop_ack", host_ack, 0);
        tick();
        core_stop = 0; #1;
        chk("cont_done", done, 1);
        chk("cont_cycles6", run_cycles, 6);
        chk("cont_mem3", mem[3], 16'h0033);
        if (!il) begin
            chk("cont_done_ack", host_ack, 1);
            tick();
            host_req = 0; #1;
            chk("cont_late_rvalid", host_rvalid, 1);
            chk("cont_late_rdata", host_rdata, 16'h0005);
        end

        // cmd_start beats cmd_clear in DONE; then 20-cycle run for saturation.
        cmd_start = 1; cmd_clear = 1;
        tick();
        cmd_start = 0; cmd_clear = 0;
        chk("both_cstart", core_start, 1);
        chk("both_done", done, 0);
        tick();
        for (int i = 1; i <= 20; i++) begin
            core_stop = (i == 20);
            tick();
        end
        core_stop = 0;
        chk("sat_main20", run_cycles, 20);
        chk("sat_cnt15", s_run_cycles, 15);
        cmd_clear = 1;
        tick();
        cmd_clear = 0;

        // Reset mid-run with a host read in flight.
        cmd_start = 1;
        tick();
        cmd_start = 0;
        tick();
        host_req = 1; host_we = 0; host_addr = 1; #1;
        chk("mid_ack", host_ack, il);
        tick();
        rst = 0; core_rd = 1; #1;
        chk("mid_busy", busy, 0);
        chk("mid_cycles", run_cycles, 0);
        chk("mid_rvalid", host_rvalid, 0);
        chk("mid_ack_rst", host_ack, 0);
        chk("mid_memrd", mem_rd, 0);
        tick();
        rst = 1; core_rd = 0; #1;
        chk("post_rst_idle_ack", host_ack, 1);
        tick();
        host_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_run_arbiter.md
# dm_run_arbiter

Run controller and data-memory arbiter for the 16-bit pipelined processor. It shares a single-port data memory (1-cycle registered read) between the processor core's dm port and a host port. The host port is used to preload operands and read back results. The block also sequences a run: it issues the core's one-cycle `start` pulse, tracks the core's `stop`, and counts run cycles.

## Interface
- `ADDR_WIDTH`, 8, memory address width
- `DATA_WIDTH`, 16, memory data width
- `CNT_WIDTH`, 16, run-cycle counter width
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: reset, asynchronous, active-low
- `cmd_start` in 1: host request to launch a run
- `cmd_clear` in 1: host acknowledge of a finished run
- `busy` out 1: high in START or RUN
- `done` out 1: high in DONE
- `run_cycles` out CNT_WIDTH: cycles spent in RUN, saturating
- `core_start` out 1: one-cycle start pulse to the core
- `core_stop` in 1: core finished
- `core_rd`, `core_wr` in 1: core dm read/write enables
- `core_addr` in ADDR_WIDTH; `core_w_data` in DATA_WIDTH
- `core_r_data` out DATA_WIDTH: equals `mem_r_data`
- `host_req` in 1; `host_we` in 1; `host_addr` in ADDR_WIDTH; `host_wdata` in DATA_WIDTH
- `host_ack` out 1: combinational; the host access is performed this cycle
- `host_rvalid` out 1; `host_rdata` out DATA_WIDTH: read return
- `mem_rd`, `mem_wr` out 1; `mem_addr` out ADDR_WIDTH; `mem_w_data` out DATA_WIDTH
- `mem_r_data` in DATA_WIDTH: valid the cycle after `mem_rd`

## Operation
- FSM states and encodings: IDLE=0, START=1, RUN=2, DONE=3.
- IDLE: on `cmd_start`, go to START.
- START: go to RUN unconditionally. `core_start` is high for exactly this one cycle.
- RUN: on `core_stop`, go to DONE. `core_stop` is ignored in every other state.
- DONE: on `cmd_start`, go to START. Otherwise, on `cmd_clear`, go to IDLE. `cmd_start` wins if both are high.
- Memory ownership:
  - IDLE and DONE: the host owns the memory. `host_ack = host_req`. Core enables are dropped.
  - START and RUN: the core owns the memory. Core signals pass straight to the mem port. Host service in these states is set by Configuration.
- Core rd+wr in the same cycle: the write is performed and `mem_rd` is forced low.
- Host access: `host_we=1` performs a write, `host_we=0` a read. An unacknowledged request must be held stable by the host until `host_ack`.
- Read return: a 1-bit register records a host-read grant. In the next cycle `host_rvalid=1` and `host_rdata = mem_r_data`. Otherwise `host_rdata` is 0.
- `run_cycles`:
  - cleared on entry to START;
  - increments each cycle in RUN, including the cycle `core_stop` is sampled;
  - saturates at all-ones;
  - holds in DONE and IDLE.
- Reset (async assert, at any time including mid-run): state=IDLE, `run_cycles`=0, rvalid register=0. All outputs read 0 except `core_r_data`, which passes `mem_r_data` through. An in-flight host read is discarded with no `host_rvalid`.

## Timing
- Host write acked in cycle N: memory updated at the posedge ending cycle N.
- Host read acked in cycle N: `host_rvalid` and data arrive in cycle N+1. Back-to-back reads sustain 1 per cycle.
- `cmd_start` sampled at edge E: START for the cycle after E, RUN from edge E+1.
- `core_stop` sampled high in RUN: `done` high the next cycle. A run of k RUN cycles reports `run_cycles`=k.
- Core path is fully combinational, adding zero latency.

## Configuration
- `HOST_INTERLEAVE_EN` defined: in START/RUN the host is acked in any cycle with `core_rd=0` and `core_wr=0`. The core always wins a conflict.
- `HOST_INTERLEAVE_EN` undefined: `host_ack=0` throughout START and RUN. Host requests stay pending until DONE.

## Test plan
- Preload then readback:
  - stimulus: in IDLE, host writes addr 1=0x000A and addr 2=0x0005, then reads addr 1 and addr 2 back to back;
  - required: `host_ack` each cycle; `host_rvalid` one cycle later with 0x000A, then 0x0005.
- Run sequence:
  - stimulus: `cmd_start` pulse; core issues a write of 10 to addr 1; `core_stop` after 7 RUN cycles;
  - required: `core_start` high exactly 1 cycle; memory[1]=10; `done`=1; `run_cycles`=7;
  - then `cmd_clear`: required return to IDLE with `run_cycles` held at 7.
- Host contention in RUN:
  - stimulus: host read pending while core reads every cycle, then the core goes idle for 1 cycle;
  - required without the macro: no ack until DONE;
  - required with the macro: ack in the idle cycle, rvalid next cycle.
- Core rd+wr in the same cycle: required `mem_wr=1`, `mem_rd=0`.
- Reset mid-run:
  - stimulus: drive `rst` low during RUN with a host read in flight;
  - required: immediately IDLE, `busy`=0, `run_cycles`=0, no `host_rvalid`.
- Saturation: with `CNT_WIDTH`=4 and 20 RUN cycles, required `run_cycles`=15.
